// File: rtl/lmul_pkg.sv
// Shared widths and helpers for the dividend-reconstruction multiplier.
package lmul_pkg;

   localparam int unsigned QUOTIENT_WIDTH_DEF    = 10;
   localparam int unsigned DENOMINATOR_WIDTH_DEF = 10;
   localparam int unsigned REMAINDER_WIDTH_DEF   = 10;

   // Capture stage + one shift-add stage per quotient bit + sign-fix/add stage.
   function automatic int unsigned lmul_latency(input int unsigned qw);
      return qw + 2;
   endfunction

   function automatic int unsigned lmul_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned LATENCY = lmul_latency(QUOTIENT_WIDTH_DEF);

endpackage

// File: rtl/lmul_stage.sv
// One registered shift-add step of the MSB-first unsigned multiply; operands ride alongside.
module lmul_stage
   import lmul_pkg::*;
#(
   parameter int unsigned QUOTIENT_WIDTH    = QUOTIENT_WIDTH_DEF,
   parameter int unsigned DENOMINATOR_WIDTH = DENOMINATOR_WIDTH_DEF,
   parameter int unsigned REMAINDER_WIDTH   = REMAINDER_WIDTH_DEF,
   parameter int unsigned BIT_INDEX         = 0
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [QUOTIENT_WIDTH+DENOMINATOR_WIDTH-1:0] i_acc,
   input  logic [QUOTIENT_WIDTH-1:0]                   i_mag,
   input  logic [DENOMINATOR_WIDTH-1:0]                i_den,
   input  logic [REMAINDER_WIDTH-1:0]                  i_rem,
   input  logic                                        i_neg,
   input  logic                                        i_valid,
   output logic [QUOTIENT_WIDTH+DENOMINATOR_WIDTH-1:0] o_acc,
   output logic [QUOTIENT_WIDTH-1:0]                   o_mag,
   output logic [DENOMINATOR_WIDTH-1:0]                o_den,
   output logic [REMAINDER_WIDTH-1:0]                  o_rem,
   output logic                                        o_neg,
   output logic                                        o_valid
);

   localparam int unsigned AW = QUOTIENT_WIDTH + DENOMINATOR_WIDTH;

   logic [AW-1:0]                w_addend;
   logic [AW-1:0]                r_acc;
   logic [QUOTIENT_WIDTH-1:0]    r_mag;
   logic [DENOMINATOR_WIDTH-1:0] r_den;
   logic [REMAINDER_WIDTH-1:0]   r_rem;
   logic                         r_neg;
   logic                         r_valid;

   always_comb begin
      w_addend = i_mag[BIT_INDEX] ? {{QUOTIENT_WIDTH{1'b0}}, i_den} : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc   <= '0;
         r_mag   <= '0;
         r_den   <= '0;
         r_rem   <= '0;
         r_neg   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_acc   <= (i_acc << 1) + w_addend;
         r_mag   <= i_mag;
         r_den   <= i_den;
         r_rem   <= i_rem;
         r_neg   <= i_neg;
         r_valid <= i_valid;
      end
   end

   assign o_acc   = r_acc;
   assign o_mag   = r_mag;
   assign o_den   = r_den;
   assign o_rem   = r_rem;
   assign o_neg   = r_neg;
   assign o_valid = r_valid;

endmodule

// File: rtl/lmul.sv
// Pipelined signed dividend reconstruction: product = quotient * denominator + remainder.
module lmul
   import lmul_pkg::*;
#(
   parameter int unsigned QUOTIENT_WIDTH    = QUOTIENT_WIDTH_DEF,
   parameter int unsigned DENOMINATOR_WIDTH = DENOMINATOR_WIDTH_DEF,
   parameter int unsigned REMAINDER_WIDTH   = REMAINDER_WIDTH_DEF,
   parameter int unsigned PRODUCT_WIDTH     = QUOTIENT_WIDTH + DENOMINATOR_WIDTH + 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic signed [QUOTIENT_WIDTH-1:0]    quotient_in,
   input  logic        [DENOMINATOR_WIDTH-1:0] denominator_in,
   input  logic signed [REMAINDER_WIDTH-1:0]   remainder_in,
   input  logic                                valid_in,
   output logic signed [PRODUCT_WIDTH-1:0]     product_out,
   output logic                                valid_out,
   output logic signed [QUOTIENT_WIDTH-1:0]    quotient_out,
   output logic        [DENOMINATOR_WIDTH-1:0] denominator_out,
   output logic signed [REMAINDER_WIDTH-1:0]   remainder_out
);

   localparam int unsigned QW = QUOTIENT_WIDTH;
   localparam int unsigned DW = DENOMINATOR_WIDTH;
   localparam int unsigned RW = REMAINDER_WIDTH;
   localparam int unsigned PW = PRODUCT_WIDTH;
   localparam int unsigned AW = QW + DW;
   // Wide enough for the signed sum without overflow, and for any requested product width.
   localparam int unsigned EW = lmul_max(lmul_max(AW, RW) + 2, PW);

   logic [QW-1:0] r_mag;
   logic [DW-1:0] r_den;
   logic [RW-1:0] r_rem;
   logic          r_neg;
   logic          r_valid;

   logic [AW-1:0] w_acc   [QW+1];
   logic [QW-1:0] w_mag   [QW+1];
   logic [DW-1:0] w_den   [QW+1];
   logic [RW-1:0] w_rem   [QW+1];
   logic          w_neg   [QW+1];
   logic          w_valid [QW+1];

   logic [EW-1:0] w_acc_ext;
   logic [EW-1:0] w_acc_signed;
   logic [EW-1:0] w_rem_ext;
   logic [QW-1:0] w_quo;

   logic [PW-1:0] r_product;
   logic          r_valid_out;
   logic [QW-1:0] r_quo_out;
   logic [DW-1:0] r_den_out;
   logic [RW-1:0] r_rem_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mag   <= '0;
         r_neg   <= 1'b0;
         r_den   <= '0;
         r_rem   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_mag   <= quotient_in[QW-1] ? -quotient_in : quotient_in;
         r_neg   <= quotient_in[QW-1];
         r_den   <= denominator_in;
         r_rem   <= remainder_in;
         r_valid <= valid_in;
      end
   end

   assign w_acc[0]   = '0;
   assign w_mag[0]   = r_mag;
   assign w_den[0]   = r_den;
   assign w_rem[0]   = r_rem;
   assign w_neg[0]   = r_neg;
   assign w_valid[0] = r_valid;

   for (genvar g = 1; g <= QW; g++) begin : g_stage
      lmul_stage #(
         .QUOTIENT_WIDTH    (QW),
         .DENOMINATOR_WIDTH (DW),
         .REMAINDER_WIDTH   (RW),
         .BIT_INDEX         (QW - g)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .i_acc   (w_acc[g-1]),
         .i_mag   (w_mag[g-1]),
         .i_den   (w_den[g-1]),
         .i_rem   (w_rem[g-1]),
         .i_neg   (w_neg[g-1]),
         .i_valid (w_valid[g-1]),
         .o_acc   (w_acc[g]),
         .o_mag   (w_mag[g]),
         .o_den   (w_den[g]),
         .o_rem   (w_rem[g]),
         .o_neg   (w_neg[g]),
         .o_valid (w_valid[g])
      );
   end

   always_comb begin
      w_acc_ext    = {{(EW-AW){1'b0}}, w_acc[QW]};
      w_acc_signed = w_neg[QW] ? -w_acc_ext : w_acc_ext;
      w_rem_ext    = {{(EW-RW){w_rem[QW][RW-1]}}, w_rem[QW]};
      // Magnitude plus sign rebuilds the original quotient exactly, including the most negative value.
      w_quo        = w_neg[QW] ? -w_mag[QW] : w_mag[QW];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_product   <= '0;
         r_valid_out <= 1'b0;
         r_quo_out   <= '0;
         r_den_out   <= '0;
         r_rem_out   <= '0;
      end else begin
         r_product   <= PW'(w_acc_signed + w_rem_ext);
         r_valid_out <= w_valid[QW];
         r_quo_out   <= w_quo;
         r_den_out   <= w_den[QW];
         r_rem_out   <= w_rem[QW];
      end
   end

   assign product_out     = r_product;
   assign valid_out       = r_valid_out;
   assign quotient_out    = r_quo_out;
   assign denominator_out = r_den_out;
   assign remainder_out   = r_rem_out;

endmodule

// File: doc/lmul.md
LMUL -- requirements
Module: lmul

Interface
REQ-001 Parameter QUOTIENT_WIDTH, default 10: width of signed quotient_in.
REQ-002 Parameter DENOMINATOR_WIDTH, default 10: width of unsigned denominator_in.
REQ-003 Parameter REMAINDER_WIDTH, default 10: width of signed remainder_in.
REQ-004 Parameter PRODUCT_WIDTH, default QUOTIENT_WIDTH+DENOMINATOR_WIDTH+1: width of signed product_out.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-007 quotient_in  input  QUOTIENT_WIDTH  signed multiplier operand.
REQ-008 denominator_in  input  DENOMINATOR_WIDTH  unsigned multiplicand.
REQ-009 remainder_in  input  REMAINDER_WIDTH  signed addend.
REQ-010 valid_in  input  1  operands valid this cycle.
REQ-011 product_out  output  PRODUCT_WIDTH  signed quotient*denominator+remainder.
REQ-012 valid_out  output  1  product_out and pass-through outputs valid.
REQ-013 quotient_out, denominator_out, remainder_out  output  same widths as inputs  operands aligned with product_out.

Function
REQ-014 Block SHALL reconstruct a dividend: product = quotient*denominator + remainder, signed arithmetic, remainder sign-extended.
REQ-015 Pipeline SHALL be LATENCY = QUOTIENT_WIDTH+2 register stages: stage 0 capture, stages 1..QUOTIENT_WIDTH shift-add, final stage sign-fix and add.
REQ-016 Stage 0 SHALL register |quotient_in| as QUOTIENT_WIDTH-bit unsigned, a negative flag, denominator, remainder and valid.
REQ-017 Stage i (1..QUOTIENT_WIDTH) SHALL set acc_i = (acc_{i-1} << 1) + (magnitude bit QUOTIENT_WIDTH-i ? denominator : 0), MSB first, acc_0 = 0, accumulator QUOTIENT_WIDTH+DENOMINATOR_WIDTH bits unsigned.
REQ-018 Final stage SHALL register product = (negative ? -acc : acc) + sign-extended remainder, truncated to PRODUCT_WIDTH (wrap, no saturation).
REQ-019 valid_out SHALL assert exactly LATENCY cycles after valid_in is sampled high; one result per cycle, no backpressure, bubbles preserved in order.
REQ-020 Operands, sign flag and valid SHALL advance every cycle regardless of valid; outputs during valid_out=0 are don't-care.
REQ-021 quotient_in = -2^(QUOTIENT_WIDTH-1) SHALL yield magnitude 2^(QUOTIENT_WIDTH-1) with correct product.
REQ-022 denominator_in = 0 SHALL yield product_out = remainder_in; quotient_in = 0 likewise.
REQ-023 With default widths the product SHALL never wrap; wrap only when PRODUCT_WIDTH is reduced.

Reset
REQ-024 While reset is high at a clock edge, all stage registers SHALL clear to 0 and valid_out SHALL be 0 on the following cycle.
REQ-025 Reset mid-operation SHALL discard all in-flight operands; no valid_out asserts until LATENCY cycles after the first valid_in sampled after reset deasserts.
REQ-026 Reset values: product_out 0, valid_out 0, quotient_out 0, denominator_out 0, remainder_out 0.

Structure
REQ-027 Package lmul_pkg SHALL hold default width constants and a LATENCY constant derived from QUOTIENT_WIDTH.
REQ-028 One sub-module lmul_stage SHALL implement a single shift-add stage (acc, magnitude, bit index, denominator, remainder, sign, valid), instantiated QUOTIENT_WIDTH times by generate.
REQ-029 Sign-fix/add stage and stage 0 SHALL reside in lmul top level.

Verification
REQ-030 quotient -3, denominator 5, remainder -2, valid one cycle -> product_out -17, valid_out high exactly 12 cycles later, one cycle wide.
REQ-031 quotient -512, denominator 1023, remainder 0 -> product_out -523776; quotient 511, denominator 1023, remainder 511 -> 523264.
REQ-032 Back-to-back stream of 20 valid operands with 3 interleaved bubbles -> 20 correct products in order, bubbles at matching positions, pass-through fields aligned.
REQ-033 Reset asserted 5 cycles after valid_in -> valid_out stays 0 through LATENCY+5 cycles; next operand after reset -> correct product at LATENCY.
REQ-034 Random round trip: numerator n, denominator d != 0, q = trunc(n/d), r = n - q*d -> product_out = n for 10000 vectors, including d = 1 and n = -512.
REQ-035 denominator 0, quotient 7, remainder -5 -> product_out -5.
